// File: rtl/demon_sweep_scheduler.sv
// demon_sweep_scheduler
//   Shares one neuron-update datapath across NUM_UNITS neuron slots. A
//   prescaler turns clk into a simulation tick; every tick starts a sweep
//   that issues one valid/ready request per slot (idx 0..N-1), collects
//   each slot's spike result into a shadow vector, and publishes the whole
//   vector once the last slot has answered.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   ena          design enable; 0 freezes the prescaler only
//   tick         1-cycle pulse when the prescaler wraps (combinational)
//   req_valid    update request to the datapath
//   req_ready    datapath accepts the request
//   req_idx      slot index of the current request
//   rsp_valid    datapath result strobe (honoured only while waiting)
//   rsp_spike    spike result for slot req_idx
//   spikes       spike vector of the last completed sweep
//   sweep_done   1-cycle pulse, spikes has just been updated
//   busy         a sweep is in progress
//   overrun      sticky, a tick was dropped
module demon_sweep_scheduler #(
  parameter  int unsigned MAX_COUNT = 1000,
  parameter  int unsigned NUM_UNITS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  output logic                 tick,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [IDX_W-1:0]     req_idx,
  input  logic                 rsp_valid,
  input  logic                 rsp_spike,
  output logic [NUM_UNITS-1:0] spikes,
  output logic                 sweep_done,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned      CNT_W    = $clog2(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_UNITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic [NUM_UNITS-1:0] shadow_q, shadow_d;
  logic [NUM_UNITS-1:0] spikes_q, spikes_d;
  logic                 req_valid_q, req_valid_d;
  logic                 sweep_done_q, sweep_done_d;
  logic                 busy_q, busy_d;
  logic                 tick_c;

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    shadow_d     = shadow_q;
    spikes_d     = spikes_q;

    // Prescaler: free-runs while enabled, wraps on the tick edge.
    tick_c = ena && (cnt_q == CNT_LAST);
    if (ena) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    // A tick that lands mid-sweep is queued once; a second one is lost.
    if (tick_c && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
      if (pending_q) begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (tick_c || pending_q) begin
          idx_d   = '0;
          state_d = S_REQ;
          // A queued tick is consumed; a fresh tick on the same edge re-queues.
          pending_d = pending_q && tick_c;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          shadow_d[idx_q] = rsp_spike;
          if (idx_q == IDX_LAST) begin
            state_d  = S_DONE;
            // Publish on entry to DONE so spikes is valid alongside sweep_done.
            spikes_d = shadow_d;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_valid_d  = (state_d == S_REQ);
    sweep_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      shadow_q     <= '0;
      spikes_q     <= '0;
      req_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      shadow_q     <= shadow_d;
      spikes_q     <= spikes_d;
      req_valid_q  <= req_valid_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
    end
  end

  assign tick       = tick_c;
  assign req_valid  = req_valid_q;
  assign req_idx    = idx_q;
  assign spikes     = spikes_q;
  assign sweep_done = sweep_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_demon_sweep_scheduler.sv
// Testbench for demon_sweep_scheduler: the bench plays the datapath
// (ready/response timing under its own control) and predicts every output
// each cycle from a step-counter model of the sweep rules.
module tb_demon_sweep_scheduler;

  localparam int MAXC = 10;
  localparam int N    = 4;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          tick;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_idx;
  logic          rsp_valid;
  logic          rsp_spike;
  logic [N-1:0]  spikes;
  logic          sweep_done;
  logic          busy;
  logic          overrun;

  demon_sweep_scheduler #(
    .MAX_COUNT(MAXC),
    .NUM_UNITS(N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .tick      (tick),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .rsp_valid (rsp_valid),
    .rsp_spike (rsp_spike),
    .spikes    (spikes),
    .sweep_done(sweep_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;

  // Stimulus knobs
  logic         rst_val;
  logic         ena_val;
  bit           ena_rand;
  int           rdy_pct;
  int           d_min, d_max;
  bit           noise_en;
  bit           spk_rand;
  logic [N-1:0] spk_pat;
  int           stall_slot, stall_len, stall_left;

  // Datapath responder
  int   r_cnt;
  logic r_spike;

  // Reference model: m_step -1 idle, 2k = requesting slot k, 2k+1 = awaiting slot k, 2N = done
  int           m_cnt;
  int           m_step;
  bit           m_pending, m_overrun;
  logic [N-1:0] m_shadow, m_spikes;

  // Observations of the last checked cycle
  bit o_tick, o_done, o_busy, o_rv;
  int o_idx;
  int acc_q[$];

  task automatic model_reset();
    m_cnt = 0; m_step = -1; m_pending = 0; m_overrun = 0;
    m_shadow = '0; m_spikes = '0; r_cnt = -1; stall_left = 0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic cyc();
    bit            e_tick, e_rv, e_busy, e_done, e_ovr;
    logic [N-1:0]  e_spk;
    logic [IW-1:0] e_idx;
    int            slot;
    @(posedge clk); #1;
    rst_n = rst_val;
    ena   = ena_rand ? ($urandom_range(7) != 0) : ena_val;
    if (stall_slot >= 0 && m_step == 2 * stall_slot) begin
      stall_left = stall_len; stall_slot = -1;
    end
    if (stall_left > 0) begin
      req_ready = 1'b0; stall_left--;
    end else begin
      req_ready = (int'($urandom_range(99)) < rdy_pct);
    end
    rsp_valid = 1'b0;
    rsp_spike = 1'($urandom_range(1));
    if (m_step >= 0 && m_step < 2 * N && (m_step % 2) == 1) begin
      if (r_cnt == 0) begin
        rsp_valid = 1'b1; rsp_spike = r_spike;
      end else begin
        r_cnt--;
      end
    end else if (noise_en && $urandom_range(3) == 0) begin
      rsp_valid = 1'b1; rsp_spike = 1'b1;
    end
    #1;
    @(negedge clk);
    slot = (m_step >= 0) ? m_step / 2 : 0;
    if (!rst_n) begin
      e_tick = 0; e_rv = 0; e_busy = 0; e_done = 0; e_ovr = 0; e_spk = '0; e_idx = '0;
    end else begin
      e_tick = ena && (m_cnt == MAXC - 1);
      e_rv   = (m_step >= 0) && (m_step < 2 * N) && ((m_step % 2) == 0);
      e_busy = (m_step >= 0);
      e_done = (m_step == 2 * N);
      e_ovr  = m_overrun;
      e_spk  = m_spikes;
      e_idx  = IW'(slot);
    end
    n_total++;
    if (tick !== e_tick) $display("FAIL tick cyc=%0d got=%b want=%b", cyc_n, tick, e_tick);
    else n_pass++;
    n_total++;
    if (req_valid !== e_rv) $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc_n, req_valid, e_rv);
    else n_pass++;
    if (e_rv || !rst_n) begin
      n_total++;
      if (req_idx !== e_idx) $display("FAIL req_idx cyc=%0d got=%0d want=%0d", cyc_n, req_idx, e_idx);
      else n_pass++;
    end
    n_total++;
    if (busy !== e_busy) $display("FAIL busy cyc=%0d got=%b want=%b", cyc_n, busy, e_busy);
    else n_pass++;
    n_total++;
    if (sweep_done !== e_done) $display("FAIL sweep_done cyc=%0d got=%b want=%b", cyc_n, sweep_done, e_done);
    else n_pass++;
    n_total++;
    if (spikes !== e_spk) $display("FAIL spikes cyc=%0d got=%b want=%b", cyc_n, spikes, e_spk);
    else n_pass++;
    n_total++;
    if (overrun !== e_ovr) $display("FAIL overrun cyc=%0d got=%b want=%b", cyc_n, overrun, e_ovr);
    else n_pass++;

    o_tick = (tick === 1'b1); o_done = (sweep_done === 1'b1);
    o_busy = (busy === 1'b1); o_rv = (req_valid === 1'b1); o_idx = int'(req_idx);
    if (o_rv && req_ready) acc_q.push_back(o_idx);

    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_step == -1) begin
        if (e_tick || m_pending) begin
          m_step    = 0;
          m_pending = m_pending && e_tick;
        end
      end else begin
        if (e_tick) begin
          if (m_pending) m_overrun = 1;
          m_pending = 1;
        end
        if (m_step == 2 * N) begin
          m_step = -1;
        end else if ((m_step % 2) == 0) begin
          if (req_ready) begin
            m_step++;
            r_cnt   = d_min + int'($urandom_range(d_max - d_min)) - 1;
            r_spike = spk_rand ? 1'($urandom_range(1)) : spk_pat[slot];
          end
        end else if (rsp_valid) begin
          m_shadow[slot] = rsp_spike;
          m_step++;
          r_cnt = -1;
          if (m_step == 2 * N) m_spikes = m_shadow;
        end
      end
      if (ena) m_cnt = (m_cnt + 1) % MAXC;
    end
    cyc_n++;
  endtask

  task automatic wait_tick_idle(output int t, input int limit);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (o_tick && !o_busy) begin t = cyc_n - 1; break; end
    end
    if (t < 0) begin
      n_total++;
      $display("FAIL tick_in_idle timeout got=none want=tick within %0d cycles", limit);
    end
  endtask

  task automatic wait_done(output int t, input int limit);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (o_done) begin t = cyc_n - 1; break; end
    end
    if (t < 0) begin
      n_total++;
      $display("FAIL sweep_done timeout got=none want=pulse within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst_val = 0; ena_val = 1;
    model_reset();
    repeat (3) cyc();
    n_total++;
    if ({tick, req_valid, busy, sweep_done, overrun} !== 5'b0 || spikes !== '0 || req_idx !== '0)
      $display("FAIL reset_outputs got=%b%b%b%b%b/%b/%0d want=all zero",
               tick, req_valid, busy, sweep_done, overrun, spikes, req_idx);
    else n_pass++;
    rst_val = 1;
  endtask

  task automatic test_basic();
    int t, d;
    wait_tick_idle(t, 3 * MAXC);
    acc_q.delete();
    wait_done(d, 40);
    n_total++;
    if (d - t !== 9) $display("FAIL basic_latency got=%0d want=9", d - t);
    else n_pass++;
    n_total++;
    if (acc_q.size() != 4 || acc_q[0] != 0 || acc_q[1] != 1 || acc_q[2] != 2 || acc_q[3] != 3)
      $display("FAIL basic_idx_seq got=%p want=0,1,2,3", acc_q);
    else n_pass++;
    n_total++;
    if (spikes !== 4'b1101) $display("FAIL basic_spikes got=%b want=1101", spikes);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    int t, d;
    wait_tick_idle(t, 3 * MAXC);
    stall_slot = 2; stall_len = 5;
    acc_q.delete();
    wait_done(d, 60);
    n_total++;
    if (d - t !== 14) $display("FAIL backpressure_latency got=%0d want=14", d - t);
    else n_pass++;
    n_total++;
    if (acc_q.size() != 4 || acc_q[2] != 2) $display("FAIL backpressure_idx_seq got=%p want=0,1,2,3", acc_q);
    else n_pass++;
    n_total++;
    if (spikes !== 4'b1101) $display("FAIL backpressure_spikes got=%b want=1101", spikes);
    else n_pass++;
  endtask

  task automatic test_ignore_rsp();
    int d;
    noise_en = 1; spk_pat = 4'b0000;
    wait_done(d, 60);
    wait_done(d, 60);
    n_total++;
    if (spikes !== 4'b0000) $display("FAIL ignore_rsp_spikes got=%b want=0000", spikes);
    else n_pass++;
    noise_en = 0; spk_pat = 4'b1101;
  endtask

  task automatic test_ena_freeze();
    int ticks, n;
    for (int i = 0; i < 3 * MAXC; i++) begin
      cyc();
      if (m_cnt == 3) break;
    end
    ena_val = 0; ticks = 0;
    repeat (20) begin cyc(); if (o_tick) ticks++; end
    n_total++;
    if (ticks != 0) $display("FAIL ena_freeze_ticks got=%0d want=0", ticks);
    else n_pass++;
    ena_val = 1; n = 0;
    for (int i = 0; i < 3 * MAXC; i++) begin
      cyc();
      if (o_tick) break;
      n++;
    end
    n_total++;
    if (n != MAXC - 4) $display("FAIL ena_resume_delay got=%0d want=%0d", n, MAXC - 4);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int t, d;
    wait_tick_idle(t, 8 * MAXC);
    d_min = 4; d_max = 4;
    wait_done(d, 60);
    n_total++;
    if (d - t !== 21) $display("FAIL overrun_sweep_len got=%0d want=21", d - t);
    else n_pass++;
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set got=%b want=1", overrun);
    else n_pass++;
    cyc();
    n_total++;
    if (busy !== 1'b0) $display("FAIL overrun_idle_gap got=%b want=0", busy);
    else n_pass++;
    cyc();
    n_total++;
    if (req_valid !== 1'b1 || req_idx !== 2'd0)
      $display("FAIL pending_restart got=%b/%0d want=1/0", req_valid, req_idx);
    else n_pass++;
    repeat (80) cyc();
    d_min = 1; d_max = 1;
    repeat (40) cyc();
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky got=%b want=1", overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int last_rst, t, dones;
    for (int i = 0; i < 8 * MAXC; i++) begin
      cyc();
      if (m_step == 2) break;
    end
    rst_val = 0;
    cyc();
    n_total++;
    if ({req_valid, busy, sweep_done, overrun, tick} !== 5'b0 || req_idx !== '0 || spikes !== '0)
      $display("FAIL reset_mid_outputs got=%b%b%b%b%b/%0d/%b want=all zero",
               req_valid, busy, sweep_done, overrun, tick, req_idx, spikes);
    else n_pass++;
    dones = 0;
    repeat (2) begin cyc(); if (o_done) dones++; end
    last_rst = cyc_n - 1;
    rst_val = 1;
    t = -1;
    for (int i = 0; i < 3 * MAXC; i++) begin
      cyc();
      if (o_done) dones++;
      if (o_tick) begin t = cyc_n - 1; break; end
    end
    n_total++;
    if (t - last_rst != MAXC) $display("FAIL reset_first_tick got=%0d want=%0d", t - last_rst, MAXC);
    else n_pass++;
    n_total++;
    if (dones != 0) $display("FAIL reset_no_done got=%0d want=0", dones);
    else n_pass++;
    cyc();
    n_total++;
    if (req_valid !== 1'b1 || req_idx !== 2'd0)
      $display("FAIL reset_restart_idx got=%b/%0d want=1/0", req_valid, req_idx);
    else n_pass++;
  endtask

  task automatic test_random();
    int dones;
    rdy_pct = 70; d_min = 1; d_max = 3; spk_rand = 1; noise_en = 1; ena_rand = 1;
    dones = 0;
    repeat (1500) begin cyc(); if (o_done) dones++; end
    n_total++;
    if (dones == 0) $display("FAIL random_sweeps got=0 want=>0");
    else n_pass++;
    ena_rand = 0; noise_en = 0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_spike = 1'b0;
    rst_val = 0; ena_val = 1; ena_rand = 0; rdy_pct = 100; d_min = 1; d_max = 1;
    noise_en = 0; spk_rand = 0; spk_pat = 4'b1101; stall_slot = -1; stall_len = 0;
    model_reset();
    test_reset();
    test_basic();
    test_back_pressure();
    test_ignore_rsp();
    test_ena_freeze();
    test_overrun();
    test_reset_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
